huff_merge_ctrl: RTL
====================

Name: huff_merge_ctrl

Overview:
- Upstream control stage of the Huffman code builder; drives the per-symbol encode cells directly.
- Accepts six 8-bit symbol counts and runs five rounds of Huffman tree merging.
- Each round it picks the two lightest nodes, presents their member masks on data_s and data_l, and steps the shared state bus that the encode cells consume.

Parameters:
- CW, 8, width of each symbol count.
- WW, CW+3, node weight width; holds the sum of six counts without overflow.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; counts are sampled on this cycle.
- cnt1..cnt6  input  CW each  symbol counts for symbols 1..6.
- state  output  3  phase bus to the encode cells.
- data_l  output  6  member mask of the larger merged node; bit5 = symbol 1 ... bit0 = symbol 6.
- data_s  output  6  member mask of the smaller merged node; same bit mapping as data_l.
- done  output  1  one-cycle pulse when the tree is complete.

Behaviour:
- State encoding is fixed (shared defines): IDLE=3'd0, CODEV=3'd1, SORT=3'd2, DECODE=3'd3, FIN=3'd4. Codes 5-7 are unused and return to IDLE.
- Reset values: state=IDLE, data_l=0, data_s=0, done=0, all node registers 0, round counter 0.
- IDLE: start=1 captures cnt1..cnt6 into node weights w[i]=cnt_i (zero-extended to WW) and sets mask[i] to the one-hot symbol bit. Next state is CODEV.
- CODEV: lasts exactly 1 cycle and marks all 6 nodes active; the encode cells clear HC/M here. Next state is SORT.
- SORT: lasts 1 cycle and combinationally selects two nodes among the active ones:
  - S = lightest; L = second lightest.
  - Ordering is weight ascending; on equal weight, the smaller numeric mask ranks lighter.
  - S and L are registered. Next state is DECODE.
- DECODE: lasts exactly 1 cycle.
  - data_s = S.mask and data_l = L.mask; both are 0 in every other state.
  - At the end of the cycle: node S becomes weight w_S+w_L with mask S.mask|L.mask, node L is deactivated, and the round counter increments.
  - After round 5, next state is FIN; otherwise SORT.
- FIN: done=1 for 1 cycle, then IDLE. The final node holds weight = sum of counts and mask 6'b111111.
- Timing: with start at cycle 0, CODEV is cycle 1, SORT/DECODE alternate over cycles 2-11 (DECODE at 3,5,7,9,11), FIN is cycle 12, IDLE is cycle 13. Total latency to done is 12 cycles.
- data_l and data_s are disjoint and nonzero in every DECODE.
- start outside IDLE is ignored. A start in the same cycle as the FIN→IDLE transition is also ignored.
- Zero counts are legal; tie rules apply unchanged.
- Reset mid-operation returns immediately to IDLE with all outputs 0. A new start is accepted on the first clock after reset deasserts.
- Weights never wrap: maximum sum is 6×(2^CW−1) < 2^WW.

Optional Feature:
- Macro HUFF_DBG_EN.
- Defined: adds outputs merge_w [WW-1:0] and round [2:0].
  - merge_w = w_S+w_L during DECODE, 0 otherwise.
  - round = completed merge count (0-5), reset to 0 in CODEV.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
1. Counts 10,20,30,40,50,60 → DECODE (data_s,data_l) in order: (100000,010000), (001000,110000), (000100,000010), (000001,111000), (000110,111001). done at cycle 12.
2. All counts 0 → round1 (000001,000010), round2 (000011,000100). All five rounds complete and done fires at cycle 12.
3. All counts 255 with HUFF_DBG_EN → round1 merge_w=510; round5 merge_w=1530 with no wrap; final mask 111111.
4. start pulsed during SORT/DECODE of an active run → ignored; outputs match scenario 1 exactly.
5. reset asserted in the 3rd DECODE → next sample shows state=0, data_l=data_s=0, done=0. Then rerun scenario 1 → identical results.
6. Back-to-back runs: start on the cycle after done (IDLE) → CODEV follows. State is never 5-7 at any time; data_l & data_s == 0 every cycle.

Source files
------------

// File: rtl/huff_merge_ctrl.sv
// -----------------------------------------------------------------------------
// huff_merge_ctrl
//
// Control stage of the Huffman code builder. It captures six symbol counts on
// a start pulse and then performs five merge rounds. Each round picks the two
// lightest active nodes, shows their member masks to the encode cells and
// folds the pair into one node.
//
// Optional feature: define HUFF_DBG_EN to add the merge_w and round outputs.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-high reset
//   start            one-cycle pulse; cnt1..cnt6 are sampled in IDLE
//   cnt1..cnt6       symbol counts for symbols 1..6 (CW bits each)
//   state            phase bus to the encode cells (IDLE/CODEV/SORT/DECODE/FIN)
//   data_l           member mask of the larger node in DECODE, else 0
//   data_s           member mask of the smaller node in DECODE, else 0
//   done             one-cycle pulse in FIN
//   merge_w          (HUFF_DBG_EN) merged weight in DECODE, else 0
//   round            (HUFF_DBG_EN) completed merge count, cleared in CODEV
//
// Mask bit mapping: bit5 = symbol 1 ... bit0 = symbol 6.
// -----------------------------------------------------------------------------
module huff_merge_ctrl #(
   parameter int CW = 8,
   parameter int WW = CW + 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] cnt1,
   input  logic [CW-1:0] cnt2,
   input  logic [CW-1:0] cnt3,
   input  logic [CW-1:0] cnt4,
   input  logic [CW-1:0] cnt5,
   input  logic [CW-1:0] cnt6,
   output logic [2:0]    state,
   output logic [5:0]    data_l,
   output logic [5:0]    data_s,
   output logic          done
`ifdef HUFF_DBG_EN
   ,
   output logic [WW-1:0] merge_w,
   output logic [2:0]    round
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CODEV  = 3'd1,
      SORT   = 3'd2,
      DECODE = 3'd3,
      FIN    = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] w_q    [6];
   logic [5:0]    mask_q [6];
   logic [5:0]    act_q;          // bit i set while node i is still a live root
   logic [2:0]    s_idx_q, l_idx_q;
   logic [2:0]    s_idx_d, l_idx_d;
   logic [2:0]    round_q;
   logic [CW-1:0] cnt_a  [6];
   logic [WW-1:0] merge_sum;

   assign cnt_a[0] = cnt1;
   assign cnt_a[1] = cnt2;
   assign cnt_a[2] = cnt3;
   assign cnt_a[3] = cnt4;
   assign cnt_a[4] = cnt5;
   assign cnt_a[5] = cnt6;

   // Total of all counts fits in WW bits, so a pairwise sum never wraps.
   assign merge_sum = w_q[s_idx_q] + w_q[l_idx_q];

   // Strict ordering: weight first, then numeric mask. Live masks are disjoint
   // and nonzero, so two live nodes never compare equal.
   function automatic logic lighter(input logic [WW-1:0] wa, input logic [5:0] ma,
                                    input logic [WW-1:0] wb, input logic [5:0] mb);
      return (wa < wb) || ((wa == wb) && (ma < mb));
   endfunction

   // Single-pass selection of the lightest (S) and second-lightest (L) live node.
   always_comb begin
      logic s_vld, l_vld;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      s_idx_d = '0;
      l_idx_d = '0;
      s_vld   = 1'b0;
      l_vld   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (act_q[i]) begin
            if (!s_vld || lighter(w_q[i], mask_q[i], w_q[s_idx_d], mask_q[s_idx_d])) begin
               l_idx_d = s_idx_d;
               l_vld   = s_vld;
               s_idx_d = 3'(i);
               s_vld   = 1'b1;
            end else if (!l_vld || lighter(w_q[i], mask_q[i], w_q[l_idx_d], mask_q[l_idx_d])) begin
               l_idx_d = 3'(i);
               l_vld   = 1'b1;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register
         // samples pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   // Next state and output decode.
   always_comb begin
      state_d = state_q;
      data_s  = '0;
      data_l  = '0;
      done    = 1'b0;
`ifdef HUFF_DBG_EN
      merge_w = '0;
`endif
      case (state_q)
         IDLE:   if (start) state_d = CODEV;
         CODEV:  state_d = SORT;
         SORT:   state_d = DECODE;
         DECODE: begin
            data_s  = mask_q[s_idx_q];
            data_l  = mask_q[l_idx_q];
`ifdef HUFF_DBG_EN
            merge_w = merge_sum;
`endif
            // round_q still holds the pre-increment count in this cycle.
            state_d = (round_q == 3'd4) ? FIN : SORT;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Node table and round bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the node table is only six entries and must read as zero after
         // reset, so it is reset like any other register rather than left as RAM.
         for (int i = 0; i < 6; i++) begin
            w_q[i]    <= '0;
            mask_q[i] <= '0;
         end
         act_q   <= '0;
         s_idx_q <= '0;
         l_idx_q <= '0;
         round_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < 6; i++) begin
                     w_q[i]    <= WW'(cnt_a[i]);
                     mask_q[i] <= 6'b100000 >> i;
                  end
               end
            end
            CODEV: begin
               act_q   <= 6'b111111;
               round_q <= '0;
            end
            SORT: begin
               s_idx_q <= s_idx_d;
               l_idx_q <= l_idx_d;
            end
            DECODE: begin
               // The merged node takes over S's slot; L's slot goes dead.
               w_q[s_idx_q]    <= merge_sum;
               mask_q[s_idx_q] <= mask_q[s_idx_q] | mask_q[l_idx_q];
               act_q[l_idx_q]  <= 1'b0;
               round_q         <= round_q + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;
`ifdef HUFF_DBG_EN
   assign round = round_q;
`endif

endmodule
